// File: rtl/matrix_elementwise_engine.sv
// Element-wise MxP matrix engine: ADD/SUB/RSUB/PASS over internal A/B banks,
// streaming one result per beat with backpressure and optional writeback into A.
module matrix_elementwise_engine #(
   parameter int  M          = 3,
   parameter int  P          = 3,
   parameter int  DATA_WIDTH = 32,
   parameter bit  SATURATE   = 1'b1,
   localparam int N          = M * P,
   localparam int ADDR_W     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic                  wb_en,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic                  a_wen,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic                  b_wen,
   output logic [DATA_WIDTH-1:0] c_out,
   output logic [ADDR_W-1:0]     c_idx,
   output logic                  c_valid,
   input  logic                  c_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  sat_flag
);
   localparam int                DW       = DATA_WIDTH;
   localparam int                IW       = ADDR_W + 1;
   localparam logic [IW-1:0]     N_I      = IW'(N);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
   localparam logic [DW-1:0]     S_MAX    = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0]     S_MIN    = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [N-1:0][DW-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [1:0]           op_q, op_d;
   logic                 wb_q, wb_d;
   logic [DW-1:0]        c_out_q, c_out_d;
   logic [ADDR_W-1:0]    c_idx_q, c_idx_d;
   logic                 c_valid_q, c_valid_d;
   logic                 sat_q, sat_d;

   logic [ADDR_W-1:0]    rd_idx;
   logic [DW:0]          ea, eb, wide;
   logic                 ovf, issue;
   logic [DW-1:0]        res;

   // One extra bit of headroom makes every op exact; overflow shows as top two bits differing.
   assign rd_idx = idx_q[ADDR_W-1:0];
   assign ea     = {a_q[rd_idx][DW-1], a_q[rd_idx]};
   assign eb     = {b_q[rd_idx][DW-1], b_q[rd_idx]};

   always_comb begin
      case (op_q)
         2'b00:   wide = ea + eb;
         2'b01:   wide = ea - eb;
         2'b10:   wide = eb - ea;
         default: wide = ea;
      endcase
   end

   assign ovf   = wide[DW] ^ wide[DW-1];
   assign res   = (SATURATE && ovf) ? (wide[DW] ? S_MIN : S_MAX) : wide[DW-1:0];
   assign issue = (state_q == S_RUN) && (idx_q < N_I) && (!c_valid_q || c_ready);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      op_d      = op_q;
      wb_d      = wb_q;
      c_out_d   = c_out_q;
      c_idx_d   = c_idx_q;
      c_valid_d = c_valid_q;
      sat_d     = sat_q;
      case (state_q)
         S_IDLE: begin
            // Banks are writable only while idle, so a running op sees a stable snapshot.
            if (a_wen && ({1'b0, a_addr} < N_I)) a_d[a_addr] = a_in;
            if (b_wen && ({1'b0, b_addr} < N_I)) b_d[b_addr] = b_in;
            if (start) begin
               op_d    = op;
               wb_d    = wb_en;
               sat_d   = 1'b0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (c_valid_q && c_ready) begin
               c_valid_d = 1'b0;
               if (c_idx_q == LAST_IDX) state_d = S_DONE;
            end
            if (issue) begin
               c_out_d   = res;
               c_idx_d   = rd_idx;
               c_valid_d = 1'b1;
               idx_d     = idx_q + 1'b1;
               if (wb_q) a_d[rd_idx] = res;
               if (SATURATE && ovf) sat_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         op_q      <= 2'b00;
         wb_q      <= 1'b0;
         c_out_q   <= '0;
         c_idx_q   <= '0;
         c_valid_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         op_q      <= op_d;
         wb_q      <= wb_d;
         c_out_q   <= c_out_d;
         c_idx_q   <= c_idx_d;
         c_valid_q <= c_valid_d;
         sat_q     <= sat_d;
      end
   end

   assign c_out    = c_out_q;
   assign c_idx    = c_idx_q;
   assign c_valid  = c_valid_q;
   assign sat_flag = sat_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
endmodule
